dsm_sinc3_decimator: RTL and testbench

- Receive-side counterpart of the team's 16-bit first-order delta-sigma DAC: turns a 1-bit delta-sigma bitstream into decimated multi-bit PCM samples.
- Filter is a 3rd-order CIC (sinc3) with oversampling ratio R = 2^OSR_LOG2.
- Used for loopback checks of the DAC (its bitstream fed straight back in) and as the digital back-end of an external 1-bit modulator.
- Output is two's-complement, centred on zero, at full scale ±2^(3*OSR_LOG2-1).

---
 rtl/dsm_sinc3_decimator.sv | 91 +++++++++
 tb/tb_dsm_sinc3_decimator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_sinc3_decimator.sv
// dsm_sinc3_decimator
//   Third-order CIC (sinc3) decimator. It turns a 1-bit delta-sigma
//   bitstream into two's-complement PCM samples, one per R = 2^OSR_LOG2
//   consumed bits. Full scale is +/-2^(AW-2), with zero at mid-density.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   ena         block enable; when low, all state holds and strobes are ignored
//   bit_i       bitstream sample (1 = +full scale, 0 = -full scale)
//   bit_vld_i   one-cycle strobe; bit_i is consumed when bit_vld_i & ena
//   dout_o      signed decimated sample, updated on every decimation event
//   dout_vld_o  one-cycle pulse marking a qualified dout_o (after warm-up)
//   settled_o   high once four decimation events have passed; held until reset
module dsm_sinc3_decimator #(
  parameter  int unsigned OSR_LOG2 = 5,
  localparam int unsigned AW       = 3 * OSR_LOG2 + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 bit_i,
  input  logic                 bit_vld_i,
  output logic signed [AW-1:0] dout_o,
  output logic                 dout_vld_o,
  output logic                 settled_o
);

  // Subtracting a quarter of the modulus recentres c3 (0..R^3) onto zero.
  localparam logic [AW-1:0] QUARTER = {2'b01, {(AW-2){1'b0}}};
  localparam logic [2:0]    WARM_DONE = 3'd4;

  logic [AW-1:0]       i1, i2, i3;
  logic [AW-1:0]       d1, d2, d3;
  logic [AW-1:0]       c1, c2, c3;
  logic [AW-1:0]       x;
  logic [OSR_LOG2-1:0] dec_cnt;
  logic [2:0]          warm_cnt;
  logic                step;
  logic                dec_event;

  always_comb begin
    step      = bit_vld_i & ena;
    dec_event = step && (dec_cnt == '1);
    x         = {{(AW-1){1'b0}}, bit_i};
    // Comb chain evaluated from the pre-edge i3; arithmetic wraps mod 2^AW,
    // which is exact because AW covers the filter gain R^3.
    c1        = i3 - d1;
    c2        = c1 - d2;
    c3        = c2 - d3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      dec_cnt    <= '0;
      warm_cnt   <= '0;
      dout_o     <= '0;
      dout_vld_o <= 1'b0;
      settled_o  <= 1'b0;
    end else begin
      dout_vld_o <= 1'b0;
      if (step) begin
        i1      <= i1 + x;
        i2      <= i2 + i1;
        i3      <= i3 + i2;
        dec_cnt <= dec_cnt + 1'b1;
        if (dec_event) begin
          d1         <= i3;
          d2         <= c1;
          d3         <= c2;
          dout_o     <= $signed(c3 - QUARTER);
          dout_vld_o <= (warm_cnt == WARM_DONE);
          if (warm_cnt != WARM_DONE) begin
            warm_cnt <= warm_cnt + 3'd1;
          end
          // settled_o tracks warm_cnt == 4 with the same edge timing.
          if (warm_cnt >= 3'd3) begin
            settled_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dsm_sinc3_decimator.sv
// Directed self-checking bench for dsm_sinc3_decimator (OSR_LOG2 = 5, R = 32).
module tb_dsm_sinc3_decimator;

  logic               clk;
  logic               rst_n;
  logic               ena;
  logic               bit_i;
  logic               bit_vld_i;
  logic signed [15:0] dout_o;
  logic               dout_vld_o;
  logic               settled_o;

  int errors;
  int checks;

  int outq[$];
  int ref_q[$];
  int wide_cnt;
  int unsettled_cnt;
  int settle_step;

  dsm_sinc3_decimator #(.OSR_LOG2(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .bit_i      (bit_i),
    .bit_vld_i  (bit_vld_i),
    .dout_o     (dout_o),
    .dout_vld_o (dout_vld_o),
    .settled_o  (settled_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n     = 1'b0;
    ena       = 1'b0;
    bit_i     = 1'b0;
    bit_vld_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives a stream after a fresh reset and records every qualified output.
  // pat/plen: repeating bit pattern indexed by consumed step; use_dac selects a
  // first-order 16-bit delta-sigma DAC model held at input 0x4000 instead.
  task automatic run_stream(input logic [3:0] pat, input int plen, input bit use_dac,
                            input int nsteps, input int spacing,
                            input int gap_at, input int gap_len);
    int          steps;
    int          cyc;
    bit          prev_vld;
    bit          en;
    bit          v;
    logic        b;
    logic [15:0] dac_acc;
    logic [16:0] dac_sum;
    apply_reset();
    outq.delete();
    wide_cnt      = 0;
    unsettled_cnt = 0;
    settle_step   = -1;
    steps         = 0;
    cyc           = 0;
    prev_vld      = 1'b0;
    dac_acc       = '0;
    while (steps < nsteps && cyc < nsteps * spacing + gap_len + 100) begin
      en      = !(cyc >= gap_at && cyc < gap_at + gap_len);
      v       = (cyc % spacing) == 0;
      dac_sum = {1'b0, dac_acc} + 17'h04000;
      if (use_dac) b = dac_sum[16];
      else         b = pat[steps % plen];
      ena       = en;
      bit_vld_i = v;
      bit_i     = b;
      @(posedge clk);
      #1;
      if (v && en) begin
        steps++;
        if (use_dac) dac_acc = dac_sum[15:0];
      end
      if (dout_vld_o) begin
        outq.push_back(int'(dout_o));
        if (!settled_o) unsettled_cnt++;
        if (prev_vld) wide_cnt++;
      end
      prev_vld = dout_vld_o;
      if (settled_o && settle_step < 0) settle_step = steps;
      cyc++;
    end
    bit_vld_i = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (dout_vld_o) begin
        outq.push_back(int'(dout_o));
        if (prev_vld) wide_cnt++;
      end
      prev_vld = dout_vld_o;
    end
  endtask

  task automatic test_reset();
    int n;
    apply_reset();
    checks++;
    if (dout_o !== 16'sd0) begin errors++; $display("FAIL reset_dout actual=%0d expected=0", dout_o); end
    checks++;
    if (dout_vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld actual=%b expected=0", dout_vld_o); end
    checks++;
    if (settled_o !== 1'b0) begin errors++; $display("FAIL reset_settled actual=%b expected=0", settled_o); end
    ena = 1'b1; bit_i = 1'b1; bit_vld_i = 1'b1;
    repeat (200) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (settled_o !== 1'b1) begin errors++; $display("FAIL pre_reset_settled actual=%b expected=1", settled_o); end
    checks++;
    if (dout_o !== 16'sd16384) begin errors++; $display("FAIL pre_reset_dout actual=%0d expected=16384", dout_o); end
    // Asynchronous assertion away from any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_o !== 16'sd0) begin errors++; $display("FAIL async_reset_dout actual=%0d expected=0", dout_o); end
    checks++;
    if (dout_vld_o !== 1'b0) begin errors++; $display("FAIL async_reset_vld actual=%b expected=0", dout_vld_o); end
    checks++;
    if (settled_o !== 1'b0) begin errors++; $display("FAIL async_reset_settled actual=%b expected=0", settled_o); end
    #2;
    rst_n = 1'b1;
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (dout_vld_o) break;
    end
    checks++;
    if (n != 160) begin errors++; $display("FAIL first_vld_strobes actual=%0d expected=160", n); end
  endtask

  task automatic test_all_ones();
    run_stream(4'b1111, 1, 1'b0, 256, 1, 0, 0);
    checks++;
    if (outq.size() != 4) begin errors++; $display("FAIL ones_count actual=%0d expected=4", outq.size()); end
    foreach (outq[k]) begin
      checks++;
      if (outq[k] != 16384) begin errors++; $display("FAIL ones_dout[%0d] actual=%0d expected=16384", k, outq[k]); end
    end
    checks++;
    if (settle_step != 128) begin errors++; $display("FAIL ones_settle_step actual=%0d expected=128", settle_step); end
  endtask

  task automatic test_all_zeros();
    run_stream(4'b0000, 1, 1'b0, 256, 1, 0, 0);
    checks++;
    if (outq.size() != 4) begin errors++; $display("FAIL zeros_count actual=%0d expected=4", outq.size()); end
    foreach (outq[k]) begin
      checks++;
      if (outq[k] != -16384) begin errors++; $display("FAIL zeros_dout[%0d] actual=%0d expected=-16384", k, outq[k]); end
    end
  endtask

  task automatic test_alternating();
    run_stream(4'b0001, 2, 1'b0, 256, 1, 0, 0);
    checks++;
    if (outq.size() != 4) begin errors++; $display("FAIL alt_count actual=%0d expected=4", outq.size()); end
    foreach (outq[k]) begin
      checks++;
      if (outq[k] != 0) begin errors++; $display("FAIL alt_dout[%0d] actual=%0d expected=0", k, outq[k]); end
    end
  endtask

  task automatic test_pattern_1110();
    run_stream(4'b0111, 4, 1'b0, 256, 1, 0, 0);
    ref_q = outq;
    checks++;
    if (outq.size() != 4) begin errors++; $display("FAIL p1110_count actual=%0d expected=4", outq.size()); end
    foreach (outq[k]) begin
      checks++;
      if (outq[k] != 8192) begin errors++; $display("FAIL p1110_dout[%0d] actual=%0d expected=8192", k, outq[k]); end
    end
  endtask

  task automatic test_sparse_gaps();
    run_stream(4'b0111, 4, 1'b0, 256, 3, 100, 7);
    checks++;
    if (outq.size() != 4) begin errors++; $display("FAIL sparse_count actual=%0d expected=4", outq.size()); end
    foreach (outq[k]) begin
      checks++;
      if (outq[k] != 8192) begin errors++; $display("FAIL sparse_dout[%0d] actual=%0d expected=8192", k, outq[k]); end
    end
    for (int k = 0; k < ref_q.size() && k < outq.size(); k++) begin
      checks++;
      if (outq[k] != ref_q[k]) begin errors++; $display("FAIL sparse_vs_dense[%0d] actual=%0d expected=%0d", k, outq[k], ref_q[k]); end
    end
    checks++;
    if (wide_cnt != 0) begin errors++; $display("FAIL sparse_vld_width actual=%0d expected=0", wide_cnt); end
    checks++;
    if (unsettled_cnt != 0) begin errors++; $display("FAIL sparse_vld_unsettled actual=%0d expected=0", unsettled_cnt); end
  endtask

  task automatic test_wrap();
    int bad;
    run_stream(4'b1111, 1, 1'b0, 6400, 1, 0, 0);
    bad = 0;
    foreach (outq[k]) if (outq[k] != 16384) bad++;
    checks++;
    if (outq.size() != 196) begin errors++; $display("FAIL wrap_count actual=%0d expected=196", outq.size()); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wrap_glitches actual=%0d expected=0", bad); end
    checks++;
    if (wide_cnt != 0) begin errors++; $display("FAIL wrap_vld_width actual=%0d expected=0", wide_cnt); end
  endtask

  task automatic test_loopback();
    int bad;
    run_stream(4'b0000, 1, 1'b1, 1024, 1, 0, 0);
    bad = 0;
    foreach (outq[k]) if (outq[k] < -8193 || outq[k] > -8191) bad++;
    checks++;
    if (outq.size() != 28) begin errors++; $display("FAIL loop_count actual=%0d expected=28", outq.size()); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL loop_out_of_tol actual=%0d expected=0", bad); end
    if (outq.size() > 0) begin
      checks++;
      if (outq[outq.size()-1] < -8193 || outq[outq.size()-1] > -8191) begin
        errors++; $display("FAIL loop_last_dout actual=%0d expected=-8192", outq[outq.size()-1]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_alternating();
    test_pattern_1110();
    test_sparse_gaps();
    test_wrap();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
